// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle FSM and the datapath/memory/IO side.
// The master side is the FSM: it reads IR fields and handshakes, drives controls.
interface multicycle_control_fsm_if #(
  parameter int OPW    = 4,
  parameter int FUNKW  = 3,
  parameter int ALUOPW = 3
) ();

  logic [OPW-1:0]    Opcode;
  logic [FUNKW-1:0]  funk;
  logic              MemReady;
  logic              InValid;
  logic              OutReady;

  logic [ALUOPW-1:0] ALUOp;
  logic              SrcA;
  logic [1:0]        SrcB;
  logic [1:0]        MemtoReg;
  logic [1:0]        RegDest;
  logic [1:0]        PCSrc;
  logic              MemSrc;
  logic              RegWrite;
  logic              MemRead;
  logic              MemWrite;
  logic              IRWrite;
  logic              PCWrite;
  logic              OutputWrite;
  logic              BranchCond;
  logic              BranchNECond;
  logic              InAck;
  logic              Trap;
  logic [4:0]        State;

  modport master (
    input  Opcode, funk, MemReady, InValid, OutReady,
    output ALUOp, SrcA, SrcB, MemtoReg, RegDest, PCSrc, MemSrc,
           RegWrite, MemRead, MemWrite, IRWrite, PCWrite, OutputWrite,
           BranchCond, BranchNECond, InAck, Trap, State
  );

  modport slave (
    output Opcode, funk, MemReady, InValid, OutReady,
    input  ALUOp, SrcA, SrcB, MemtoReg, RegDest, PCSrc, MemSrc,
           RegWrite, MemRead, MemWrite, IRWrite, PCWrite, OutputWrite,
           BranchCond, BranchNECond, InAck, Trap, State
  );

endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM for the 16-bit datapath: decodes Opcode/funk into
// per-cycle datapath controls, with memory wait-states, IO handshakes and an
// illegal-opcode trap. Handshake-gated enables are combinational on the
// ready/valid inputs; everything else is a pure function of the state.
module multicycle_control_fsm #(
  parameter int OPW    = 4,
  parameter int FUNKW  = 3,
  parameter int ALUOPW = 3,
  parameter int MEM_HS = 1
) (
  input  logic                      CLK,
  input  logic                      Reset_n,
  multicycle_control_fsm_if.master  bus
);

  typedef enum logic [4:0] {
    FETCH  = 5'd0,  DECODE = 5'd1,  RTYPE = 5'd2,  RWB   = 5'd3,
    MADDR  = 5'd4,  SW     = 5'd5,  LW1   = 5'd6,  LW2   = 5'd7,
    IMM    = 5'd8,  IMMWB  = 5'd9,  JAL1  = 5'd10, JAL2  = 5'd11,
    JR     = 5'd12, J      = 5'd13, BEQ   = 5'd14, BNE   = 5'd15,
    IN     = 5'd16, OUT    = 5'd17, TRAP  = 5'd18
  } stateT;

  stateT state, nextState;
  logic  memRdy;

  // With the memory handshake disabled every access completes in one cycle.
  assign memRdy = (MEM_HS == 0) || bus.MemReady;

  assign bus.State = state;

  // State register; reset forces FETCH immediately, aborting any instruction.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= FETCH;
    else          state <= nextState;
  end

  // Next-state decode and per-state control outputs, all zero while in reset.
  always_comb begin
    nextState        = state;
    bus.ALUOp        = '0;
    bus.SrcA         = 1'b0;
    bus.SrcB         = 2'd0;
    bus.MemtoReg     = 2'd0;
    bus.RegDest      = 2'd0;
    bus.PCSrc        = 2'd0;
    bus.MemSrc       = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.PCWrite      = 1'b0;
    bus.OutputWrite  = 1'b0;
    bus.BranchCond   = 1'b0;
    bus.BranchNECond = 1'b0;
    bus.InAck        = 1'b0;
    bus.Trap         = 1'b0;

    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.SrcB    = 2'd1;
        bus.ALUOp   = ALUOPW'(2);
        if (memRdy) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          if (bus.Opcode == OPW'(12))
            nextState = (bus.funk == FUNKW'(1)) ? IN : OUT;
          else
            nextState = DECODE;
        end
      end
      DECODE: begin
        bus.SrcB  = 2'd2;
        bus.ALUOp = ALUOPW'(2);
        case (bus.Opcode)
          OPW'(0):                   nextState = RTYPE;
          OPW'(2), OPW'(3):          nextState = MADDR;
          OPW'(1), OPW'(4), OPW'(5): nextState = IMM;
          OPW'(10):                  nextState = JAL1;
          OPW'(11):                  nextState = JR;
          OPW'(9):                   nextState = J;
          OPW'(7):                   nextState = BEQ;
          OPW'(8):                   nextState = BNE;
          default:                   nextState = TRAP;
        endcase
      end
      RTYPE: begin
        bus.SrcA  = 1'b1;
        bus.ALUOp = ALUOPW'(bus.Opcode);
        nextState = RWB;
      end
      RWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'd1;
        bus.RegDest  = 2'd1;
        nextState    = FETCH;
      end
      MADDR: begin
        bus.SrcA  = 1'b1;
        bus.SrcB  = 2'd2;
        bus.ALUOp = ALUOPW'(2);
        nextState = (bus.Opcode == OPW'(2)) ? LW1 : SW;
      end
      SW: begin
        bus.MemSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        if (memRdy) nextState = FETCH;
      end
      LW1: begin
        bus.MemSrc  = 1'b1;
        bus.MemRead = 1'b1;
        if (memRdy) nextState = LW2;
      end
      LW2: begin
        bus.RegWrite = 1'b1;
        nextState    = FETCH;
      end
      IMM: begin
        bus.SrcA  = 1'b1;
        bus.SrcB  = 2'd2;
        bus.ALUOp = ALUOPW'(2);
        nextState = IMMWB;
      end
      IMMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'd1;
        nextState    = FETCH;
      end
      JAL1: begin
        bus.SrcB  = 2'd1;
        bus.ALUOp = ALUOPW'(2);
        nextState = JAL2;
      end
      JAL2: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'd1;
        bus.RegDest  = 2'd2;
        bus.PCWrite  = 1'b1;
        bus.PCSrc    = 2'd1;
        nextState    = FETCH;
      end
      JR: begin
        bus.SrcA    = 1'b1;
        bus.ALUOp   = ALUOPW'(2);
        bus.PCWrite = 1'b1;
        nextState   = FETCH;
      end
      J: begin
        bus.PCWrite = 1'b1;
        bus.PCSrc   = 2'd1;
        nextState   = FETCH;
      end
      BEQ: begin
        bus.SrcA       = 1'b1;
        bus.ALUOp      = ALUOPW'(3);
        bus.PCSrc      = 2'd2;
        bus.BranchCond = 1'b1;
        nextState      = FETCH;
      end
      BNE: begin
        bus.SrcA         = 1'b1;
        bus.ALUOp        = ALUOPW'(3);
        bus.PCSrc        = 2'd2;
        bus.BranchNECond = 1'b1;
        nextState        = FETCH;
      end
      IN: begin
        bus.MemtoReg = 2'd2;
        if (bus.InValid) begin
          bus.RegWrite = 1'b1;
          bus.InAck    = 1'b1;
          nextState    = FETCH;
        end
      end
      OUT: begin
        if (bus.OutReady) begin
          bus.OutputWrite = 1'b1;
          nextState       = FETCH;
        end
      end
      TRAP: begin
        bus.Trap = 1'b1;
      end
      default: begin
        nextState = TRAP;
      end
    endcase

    if (!Reset_n) begin
      bus.ALUOp        = '0;
      bus.SrcA         = 1'b0;
      bus.SrcB         = 2'd0;
      bus.MemtoReg     = 2'd0;
      bus.RegDest      = 2'd0;
      bus.PCSrc        = 2'd0;
      bus.MemSrc       = 1'b0;
      bus.RegWrite     = 1'b0;
      bus.MemRead      = 1'b0;
      bus.MemWrite     = 1'b0;
      bus.IRWrite      = 1'b0;
      bus.PCWrite      = 1'b0;
      bus.OutputWrite  = 1'b0;
      bus.BranchCond   = 1'b0;
      bus.BranchNECond = 1'b0;
      bus.InAck        = 1'b0;
      bus.Trap         = 1'b0;
    end
  end

endmodule
